// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/execute controller for the 4-bit simple core.
// Fetches over a req/ack handshake, then sequences ALU write-back, data-memory access and branches.
module core_sequencer #(
  parameter int                PC_LEN    = 7,
  parameter int                INSTR_LEN = 8,
  parameter logic [PC_LEN-1:0] RESET_PC  = '0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RUN,
  output logic                 IMEM_REQ,
  output logic [PC_LEN-1:0]    IMEM_ADDR,
  input  logic                 IMEM_ACK,
  input  logic [INSTR_LEN-1:0] IMEM_DATA,
  output logic [INSTR_LEN-1:0] INSTR,
  input  logic                 IS_BR,
  input  logic                 IS_LD,
  input  logic                 IS_ST,
  input  logic [PC_LEN-1:0]    BR_TARGET,
  input  logic                 COND,
  output logic                 ACC_WE,
  output logic                 DMEM_REQ,
  output logic                 DMEM_WE,
  input  logic                 DMEM_ACK,
  output logic [PC_LEN-1:0]    PC,
  output logic                 HALTED,
  output logic [15:0]          RETIRED
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

  state_t                state, state_nxt;
  logic [PC_LEN-1:0]     pc_q;
  logic [INSTR_LEN-1:0]  instr_q;
  logic                  dmem_we_q;
  logic                  halted_q;
  logic [15:0]           retired_q;

  logic                  exec_mem;
  logic                  br_taken;
  logic                  br_halt;
  logic                  retire;

  function automatic logic [PC_LEN-1:0] pc_inc(input logic [PC_LEN-1:0] p);
    return p + PC_LEN'(1);
  endfunction

  // Branch class wins over memory class when the decoder flags overlap.
  assign exec_mem = !IS_BR && (IS_LD || IS_ST);
  assign br_taken = IS_BR && COND;
  assign br_halt  = (state == EXEC) && br_taken && (BR_TARGET == pc_q);
  assign retire   = ((state == EXEC) && !exec_mem) || ((state == MEM) && DMEM_ACK);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (RUN) state_nxt = FETCH;
      FETCH:   if (IMEM_ACK) state_nxt = EXEC;
      EXEC: begin
        if (br_halt)       state_nxt = HALT;
        else if (exec_mem) state_nxt = MEM;
        else               state_nxt = RUN ? FETCH : IDLE;
      end
      MEM:     if (DMEM_ACK) state_nxt = RUN ? FETCH : IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    IMEM_REQ = 1'b0;
    DMEM_REQ = 1'b0;
    ACC_WE   = 1'b0;
    case (state)
      FETCH: IMEM_REQ = 1'b1;
      EXEC:  ACC_WE   = !IS_BR && !IS_LD && !IS_ST;
      MEM: begin
        DMEM_REQ = 1'b1;
        ACC_WE   = DMEM_ACK && !dmem_we_q;
      end
      default: ;
    endcase
  end

  // A self-loop branch retires but leaves the PC where it is.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      dmem_we_q <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if ((state == FETCH) && IMEM_ACK) instr_q <= IMEM_DATA;
      if ((state == EXEC) && exec_mem) dmem_we_q <= IS_ST;
      if (br_halt) halted_q <= 1'b1;
      if (retire) begin
        retired_q <= retired_q + 16'd1;
        if (!br_halt) pc_q <= ((state == EXEC) && br_taken) ? BR_TARGET : pc_inc(pc_q);
      end
    end
  end

  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign INSTR     = instr_q;
  assign DMEM_WE   = dmem_we_q;
  assign HALTED    = halted_q;
  assign RETIRED   = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: an instruction-level reference model queues expected retires,
// randomized memory responders drive the handshakes and a monitor checks each retire.
`timescale 1ns/1ps
module tb_core_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        RUN = 1'b0;
  logic        IMEM_REQ;
  logic [6:0]  IMEM_ADDR;
  logic        IMEM_ACK;
  logic [7:0]  IMEM_DATA;
  logic [7:0]  INSTR;
  logic        IS_BR, IS_LD, IS_ST;
  logic [6:0]  BR_TARGET;
  logic        COND;
  logic        ACC_WE;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic        DMEM_ACK;
  logic [6:0]  PC;
  logic        HALTED;
  logic [15:0] RETIRED;

  core_sequencer #(.PC_LEN(7), .INSTR_LEN(8), .RESET_PC(7'd0)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .INSTR(INSTR), .IS_BR(IS_BR), .IS_LD(IS_LD), .IS_ST(IS_ST),
    .BR_TARGET(BR_TARGET), .COND(COND), .ACC_WE(ACC_WE),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ACK(DMEM_ACK),
    .PC(PC), .HALTED(HALTED), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  // Program memory, per-address branch condition and a toy decoder:
  // bit7=1 branch to [6:0]; 0x7x load (bit3=0) or store (bit3=1); anything else is ALU.
  logic [7:0] imem [128];
  logic       cond_tab [128];
  assign IS_BR     = INSTR[7];
  assign IS_LD     = (INSTR[7:4] == 4'h7) && !INSTR[3];
  assign IS_ST     = (INSTR[7:4] == 4'h7) && INSTR[3];
  assign BR_TARGET = INSTR[6:0];
  assign COND      = cond_tab[PC];

  typedef struct {
    logic [6:0]  pc;
    logic [7:0]  instr;
    logic [6:0]  npc;
    int          accw;
    bit          mem;
    bit          we;
    bit          halt;
    logic [15:0] ret;
  } rec_t;

  rec_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [6:0]  m_pc = '0;
  logic [15:0] m_ret = '0;
  int          m_halt_at = 0;

  int iw_min = 0, iw_max = 0, dw_min = 0, dw_max = 0, stray_en = 0;
  int iw_cur = 0, iw_cnt = 0, dw_cur = 0, dw_cnt = 0;

  int          pops = 0;
  int          icyc = 0, dcyc = 0, accw_cnt = 0;
  bit          d_seen = 0, d_we = 0;
  logic [6:0]  f_addr = '0;
  logic [6:0]  last_npc = '0;
  logic [15:0] last_ret = '0;
  logic [15:0] last_exp_ret = '0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: walk the program one instruction at a time.
  function automatic int gen(input int n);
    int cnt = 0;
    rec_t r;
    m_halt_at = 0;
    for (int i = 0; i < n; i++) begin
      r.pc = m_pc;
      r.instr = imem[m_pc];
      r.accw = 0; r.mem = 0; r.we = 0; r.halt = 0;
      if (r.instr[7]) begin
        if (cond_tab[m_pc] && (r.instr[6:0] == m_pc)) begin
          r.halt = 1;
          r.npc = m_pc;
        end else begin
          r.npc = cond_tab[m_pc] ? r.instr[6:0] : m_pc + 7'd1;
        end
      end else if (r.instr[7:4] == 4'h7) begin
        r.mem = 1;
        r.we = r.instr[3];
        r.accw = r.instr[3] ? 0 : 1;
        r.npc = m_pc + 7'd1;
      end else begin
        r.accw = 1;
        r.npc = m_pc + 7'd1;
      end
      m_ret = m_ret + 16'd1;
      r.ret = m_ret;
      exp_q.push_back(r);
      cnt++;
      m_pc = r.npc;
      if (r.halt) begin
        m_halt_at = cnt;
        break;
      end
    end
    return cnt;
  endfunction

  // Memory responders: wait a chosen number of cycles, then acknowledge; optional stray acks.
  initial begin
    IMEM_ACK = 1'b0; IMEM_DATA = '0; DMEM_ACK = 1'b0;
    forever begin
      @(posedge CLK); #2;
      if (IMEM_REQ) begin
        if (iw_cnt == 0) begin
          IMEM_ACK = 1'b1;
          IMEM_DATA = imem[IMEM_ADDR];
        end else begin
          IMEM_ACK = 1'b0;
          iw_cnt--;
        end
      end else begin
        IMEM_ACK = (stray_en == 2) || ((stray_en == 1) && ($urandom_range(0, 2) == 0));
        IMEM_DATA = 8'($urandom);
        iw_cur = $urandom_range(iw_min, iw_max);
        iw_cnt = iw_cur;
      end
      if (DMEM_REQ) begin
        if (dw_cnt == 0) DMEM_ACK = 1'b1;
        else begin
          DMEM_ACK = 1'b0;
          dw_cnt--;
        end
      end else begin
        DMEM_ACK = (stray_en == 2) || ((stray_en == 1) && ($urandom_range(0, 2) == 0));
        dw_cur = $urandom_range(dw_min, dw_max);
        dw_cnt = dw_cur;
      end
    end
  end

  // Monitor: accumulate per-instruction observations, pop and compare on every retire.
  initial begin
    rec_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        icyc = 0; dcyc = 0; accw_cnt = 0; d_seen = 0; last_ret = '0;
        continue;
      end
      if (RETIRED !== last_ret) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", int'(RETIRED), int'(last_ret));
        end else begin
          e = exp_q.pop_front();
          check("retired_count", int'(RETIRED), int'(e.ret));
          check("pc_after_retire", int'(PC), int'(e.npc));
          check("fetch_addr", int'(f_addr), int'(e.pc));
          check("instr_latched", int'(INSTR), int'(e.instr));
          check("acc_we_pulses", accw_cnt, e.accw);
          check("mem_access", int'(d_seen), int'(e.mem));
          if (e.mem) check("dmem_we", int'(d_we), int'(e.we));
          check("halted", int'(HALTED), int'(e.halt));
          last_npc = e.npc;
          last_exp_ret = e.ret;
        end
        last_ret = RETIRED;
        pops++;
        accw_cnt = 0; d_seen = 0; dcyc = 0;
      end
      if (IMEM_REQ) begin
        check("imem_addr_eq_pc", int'(IMEM_ADDR), int'(PC));
        icyc++;
        if (IMEM_ACK) begin
          check("imem_req_cycles", icyc, iw_cur + 1);
          f_addr = IMEM_ADDR;
          icyc = 0;
        end
      end
      if (DMEM_REQ) begin
        if (dcyc == 0) d_we = DMEM_WE;
        else check("dmem_we_stable", int'(DMEM_WE), int'(d_we));
        dcyc++;
        d_seen = 1;
        if (DMEM_ACK) check("dmem_req_cycles", dcyc, dw_cur + 1);
      end
      if (ACC_WE) accw_cnt++;
      check("acc_we_in_fetch_or_halt", int'(ACC_WE && (IMEM_REQ || HALTED)), 0);
    end
  end

  task automatic do_reset();
    @(posedge CLK); #2;
    RESET = 1'b1;
    RUN = 1'b0;
    @(posedge CLK); #2;
    exp_q.delete();
    m_pc = '0; m_ret = '0; pops = 0;
    RESET = 1'b0;
  endtask

  task automatic run_until(input int target, input bit rand_run);
    for (int c = 0; c < 20000 && pops < target; c++) begin
      @(posedge CLK); #2;
      RUN = rand_run ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    check("retires_reached", pops, target);
  endtask

  task automatic park();
    int saved = stray_en;
    RUN = 1'b0;
    repeat (30) @(posedge CLK);
    stray_en = 2;
    repeat (10) begin
      @(negedge CLK);
      check("park_quiet", int'({IMEM_REQ, DMEM_REQ, ACC_WE}), 0);
    end
    check("park_pc", int'(PC), int'(last_npc));
    check("park_retired", int'(RETIRED), int'(last_exp_ret));
    stray_en = saved;
  endtask

  task automatic halt_check(input logic [15:0] hret);
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK); #2;
      RUN = ($urandom_range(0, 1) == 1);
      @(negedge CLK);
      check("halt_quiet", int'({IMEM_REQ, DMEM_REQ, ACC_WE, HALTED}), 1);
      check("halt_retired", int'(RETIRED), int'(hret));
    end
  endtask

  task automatic episode(input int n, input bit rand_run);
    int k, target;
    do_reset();
    k = gen(n + 4);
    target = (m_halt_at != 0 && m_halt_at <= n) ? m_halt_at : n;
    run_until(target, rand_run);
    if (m_halt_at != 0 && m_halt_at <= n) halt_check(16'(m_halt_at));
    else park();
  endtask

  task automatic prog_alu();
    for (int i = 0; i < 128; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 8'h6F));
      imem[i] = v;
      cond_tab[i] = 1'b0;
    end
    imem[0] = 8'h15;
  endtask

  initial begin
    int k;
    prog_alu();

    // Reset values, then RESET asserted mid-FETCH drops requests without a clock.
    do_reset();
    @(negedge CLK);
    check("reset_outputs", int'({IMEM_REQ, DMEM_REQ, DMEM_WE, ACC_WE, HALTED}), 0);
    check("reset_pc", int'(PC), 0);
    check("reset_instr", int'(INSTR), 0);
    check("reset_retired", int'(RETIRED), 0);
    iw_min = 2; iw_max = 2;
    RUN = 1'b1;
    for (int c = 0; c < 10 && !IMEM_REQ; c++) @(negedge CLK);
    check("fetch_started", int'(IMEM_REQ), 1);
    #1 RESET = 1'b1;
    #1;
    check("async_reset_imem_req", int'(IMEM_REQ), 0);
    check("async_reset_pc", int'(PC), 0);
    @(posedge CLK); @(posedge CLK); #2;
    exp_q.delete(); m_pc = '0; m_ret = '0; pops = 0;
    RUN = 1'b0;
    RESET = 1'b0;
    iw_min = 0; iw_max = 0;
    k = gen(9);
    run_until(5, 0);
    park();

    // Branch taken / not taken / self-loop halt at PC=3.
    imem[3] = 8'h85; cond_tab[3] = 1'b1;
    episode(6, 0);
    cond_tab[3] = 1'b0;
    episode(6, 0);
    imem[3] = 8'h83; cond_tab[3] = 1'b1;
    episode(6, 0);

    // Load with a 3-cycle ack delay, then a store.
    prog_alu();
    imem[0] = 8'h72; dw_min = 3; dw_max = 3;
    episode(3, 0);
    imem[0] = 8'h7A; dw_min = 0; dw_max = 2;
    episode(3, 0);

    // PC wrap from 127 to 0 with random waits and stray acks.
    prog_alu();
    iw_min = 0; iw_max = 2; dw_min = 0; dw_max = 2; stray_en = 1;
    episode(135, 0);

    // RUN dropped during a load's MEM wait: load completes, parks, then resumes.
    prog_alu();
    imem[0] = 8'h72; dw_min = 3; dw_max = 3; iw_min = 0; iw_max = 0; stray_en = 0;
    do_reset();
    k = gen(10);
    RUN = 1'b1;
    for (int c = 0; c < 20 && !DMEM_REQ; c++) @(negedge CLK);
    check("drop_reached_mem", int'(DMEM_REQ), 1);
    @(posedge CLK); #2;
    RUN = 1'b0;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check("drop_parked_no_req", int'({IMEM_REQ, DMEM_REQ}), 0);
    check("drop_pc_next", int'(PC), 1);
    check("drop_retired", int'(RETIRED), 1);
    run_until(6, 0);
    park();

    // Random programs, random waits, random RUN and stray acks.
    iw_min = 0; iw_max = 3; dw_min = 0; dw_max = 3; stray_en = 1;
    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < 128; i++) begin
        imem[i] = 8'($urandom);
        cond_tab[i] = 1'($urandom_range(0, 1));
      end
      episode(40, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
